// File: rtl/decode_ctrl_hazard_if.sv
// decode_ctrl_hazard_if: decode-stage bundle between the decode pipeline
// register, the register file and the ID/EX register.
//
// i_*  : latched instruction, register-file reads, E/M/W result buses
// o_*  : decoded control, extended immediate, forwarded operands, pause
// master drives i_* and observes o_*; slave is the decode control block.
interface decode_ctrl_hazard_if;
  logic [31:0] i_inst;
  logic [31:0] i_rd1;
  logic [31:0] i_rd2;
  logic [31:0] i_aluOutE;
  logic [31:0] i_resM;
  logic [31:0] i_rstW;
  logic        o_regWe;
  logic        o_dMemWe;
  logic        o_sWRD;
  logic        o_sA;
  logic        o_sB;
  logic        o_sByte;
  logic        o_srs;
  logic [3:0]  o_brOP;
  logic [4:0]  o_aluOP;
  logic [4:0]  o_WRA;
  logic [25:0] o_targetPC;
  logic [31:0] o_num;
  logic [31:0] o_rd1;
  logic [31:0] o_rd2;
  logic        o_pause;

  modport master (
    output i_inst, i_rd1, i_rd2, i_aluOutE, i_resM, i_rstW,
    input  o_regWe, o_dMemWe, o_sWRD, o_sA, o_sB, o_sByte, o_srs,
    input  o_brOP, o_aluOP, o_WRA, o_targetPC, o_num,
    input  o_rd1, o_rd2, o_pause
  );

  modport slave (
    input  i_inst, i_rd1, i_rd2, i_aluOutE, i_resM, i_rstW,
    output o_regWe, o_dMemWe, o_sWRD, o_sA, o_sB, o_sByte, o_srs,
    output o_brOP, o_aluOP, o_WRA, o_targetPC, o_num,
    output o_rd1, o_rd2, o_pause
  );
endinterface

// File: rtl/decode_ctrl_hazard.sv
// decode_ctrl_hazard: MIPS-style decode control, immediate extension and
// E/M/W write scoreboard for operand forwarding and one-bubble pauses.
//
// Ports: clk, rst (synchronous, active-high), bus (decode_ctrl_hazard_if
// slave). All bus outputs are combinational from i_* and the scoreboard.
// `define DEC_FORWARD_EN selects forwarding; without it any read of a
// pending destination pauses until the write has left W.
module decode_ctrl_hazard (
  input  logic clk,
  input  logic rst,
  decode_ctrl_hazard_if.slave bus
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLTZ = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8;
  localparam logic [3:0] BR_JR   = 4'd9;

  typedef struct packed {
    logic [4:0] wra;
    logic       we;
    logic       ld;
  } sb_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op    = bus.i_inst[31:26];
  assign rs    = bus.i_inst[25:21];
  assign rt    = bus.i_inst[20:16];
  assign rd    = bus.i_inst[15:11];
  assign sh    = bus.i_inst[10:6];
  assign funct = bus.i_inst[5:0];
  assign sext  = {{16{bus.i_inst[15]}}, bus.i_inst[15:0]};
  assign zext  = {16'h0000, bus.i_inst[15:0]};

  logic        reg_we;
  logic        dmem_we;
  logic        s_wrd;
  logic        s_a;
  logic        s_b;
  logic        s_byte;
  logic        srs;
  logic        srt;
  logic        is_load;
  logic [3:0]  br_op;
  logic [4:0]  alu_op;
  logic [4:0]  wra;
  logic [31:0] num;

  always_comb begin
    reg_we  = 1'b0;
    dmem_we = 1'b0;
    s_wrd   = 1'b0;
    s_a     = 1'b0;
    s_b     = 1'b0;
    s_byte  = 1'b0;
    srs     = 1'b0;
    srt     = 1'b0;
    is_load = 1'b0;
    br_op   = BR_NONE;
    alu_op  = ALU_ADD;
    wra     = rd;
    num     = sext;
    case (op)
      6'h00: begin
        reg_we = 1'b1;
        srs    = 1'b1;
        srt    = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2A: alu_op = ALU_SLT;
          6'h2B: alu_op = ALU_SLTU;
          6'h00, 6'h02, 6'h03: begin
            // constant shifts take the amount from the immediate path
            s_a = 1'b1;
            srs = 1'b0;
            num = {27'd0, sh};
            unique case (1'b1)
              funct[1] && funct[0]: alu_op = ALU_SRA;
              funct[1]:             alu_op = ALU_SRL;
              default:              alu_op = ALU_SLL;
            endcase
          end
          6'h04: alu_op = ALU_SLL;
          6'h06: alu_op = ALU_SRL;
          6'h07: alu_op = ALU_SRA;
          6'h08: begin
            reg_we = 1'b0;
            srt    = 1'b0;
            br_op  = BR_JR;
          end
          default: begin
            reg_we = 1'b0;
            srs    = 1'b0;
            srt    = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        s_b    = 1'b1;
        reg_we = 1'b1;
        wra    = rt;
        srs    = 1'b1;
        case (op[2:0])
          3'd0, 3'd1: alu_op = ALU_ADD;
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_AND;
          3'd5: alu_op = ALU_OR;
          3'd6: alu_op = ALU_XOR;
          default: begin
            alu_op = ALU_LUI;
            srs    = 1'b0;
          end
        endcase
        if (op[2]) num = zext;
      end
      6'h23, 6'h20: begin
        s_b     = 1'b1;
        reg_we  = 1'b1;
        s_wrd   = 1'b1;
        is_load = 1'b1;
        wra     = rt;
        srs     = 1'b1;
        s_byte  = (op == 6'h20);
      end
      6'h2B, 6'h28: begin
        s_b     = 1'b1;
        dmem_we = 1'b1;
        srs     = 1'b1;
        srt     = 1'b1;
        s_byte  = (op == 6'h28);
      end
      6'h04, 6'h05: begin
        br_op = op[0] ? BR_BNE : BR_BEQ;
        srs   = 1'b1;
        srt   = 1'b1;
      end
      6'h06, 6'h07: begin
        br_op = op[0] ? BR_BGTZ : BR_BLEZ;
        srs   = 1'b1;
      end
      6'h01: begin
        unique case (1'b1)
          rt == 5'd0: begin
            br_op = BR_BLTZ;
            srs   = 1'b1;
          end
          rt == 5'd1: begin
            br_op = BR_BGEZ;
            srs   = 1'b1;
          end
          default: ;
        endcase
      end
      6'h02: br_op = BR_J;
      6'h03: begin
        br_op  = BR_JAL;
        reg_we = 1'b1;
        wra    = 5'd31;
      end
      default: ;
    endcase
  end

  sb_t sb_e;
  sb_t sb_m;
  sb_t sb_w;
  logic pause;

  function automatic logic hit(input sb_t e, input logic [4:0] r);
    return e.we && (e.wra == r) && (r != 5'd0);
  endfunction

`ifdef DEC_FORWARD_EN
  function automatic logic [31:0] fwd(
    input logic [4:0]  r,
    input logic [31:0] rf
  );
    logic [31:0] v;
    v = rf;
    unique case (1'b1)
      hit(sb_e, r): v = bus.i_aluOutE;
      hit(sb_m, r): v = bus.i_resM;
      hit(sb_w, r): v = bus.i_rstW;
      default:      v = rf;
    endcase
    return v;
  endfunction

  // only a load still in E cannot be forwarded yet
  assign pause = sb_e.ld && ((srs && hit(sb_e, rs)) ||
                             (srt && hit(sb_e, rt)));
  assign bus.o_rd1 = fwd(rs, bus.i_rd1);
  assign bus.o_rd2 = fwd(rt, bus.i_rd2);

  logic unused_sb;
  assign unused_sb = sb_m.ld ^ sb_w.ld;
`else
  function automatic logic busy(input logic [4:0] r);
    return hit(sb_e, r) || hit(sb_m, r) || hit(sb_w, r);
  endfunction

  assign pause = (srs && busy(rs)) || (srt && busy(rt));
  assign bus.o_rd1 = bus.i_rd1;
  assign bus.o_rd2 = bus.i_rd2;

  logic unused_sb;
  assign unused_sb = ^{bus.i_aluOutE, bus.i_resM, bus.i_rstW,
                       sb_e.ld, sb_m.ld, sb_w.ld};
`endif

  assign bus.o_pause    = pause;
  assign bus.o_regWe    = reg_we & ~pause;
  assign bus.o_dMemWe   = dmem_we & ~pause;
  assign bus.o_brOP     = pause ? BR_NONE : br_op;
  assign bus.o_sWRD     = s_wrd;
  assign bus.o_sA       = s_a;
  assign bus.o_sB       = s_b;
  assign bus.o_sByte    = s_byte;
  assign bus.o_srs      = srs;
  assign bus.o_aluOP    = alu_op;
  assign bus.o_WRA      = wra;
  assign bus.o_targetPC = bus.i_inst[25:0];
  assign bus.o_num      = num;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_e <= '0;
      sb_m <= '0;
      sb_w <= '0;
    end else begin
      sb_w <= sb_m;
      sb_m <= sb_e;
      sb_e <= pause ? '0 : '{wra: wra, we: reg_we, ld: is_load};
    end
  end

endmodule

// File: tb/tb_decode_ctrl_hazard.sv
// tb_decode_ctrl_hazard: directed vectors for decode_ctrl_hazard,
// single-instruction table plus multi-cycle hazard sequences.
module tb_decode_ctrl_hazard;

`ifdef DEC_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] RD1  = 32'h1111_1111;
  localparam logic [31:0] RD2  = 32'h2222_2222;
  localparam logic [31:0] ALUE = 32'hEEEE_0001;
  localparam logic [31:0] RESM = 32'h4D4D_0002;
  localparam logic [31:0] RSTW = 32'h5757_0003;
  localparam logic [31:0] NOP  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  decode_ctrl_hazard_if bus();

  decode_ctrl_hazard dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // fl = {we, dm, wrd, sa, sb, byte, srs}; m = check {alu, wra, num}
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  alu;
    logic [3:0]  br;
    logic [6:0]  fl;
    logic [4:0]  wra;
    logic [31:0] num;
    logic [2:0]  m;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] inst);
    @(posedge clk);
    #1 bus.i_inst = inst;
    @(negedge clk);
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) step(NOP);
  endtask

  task automatic run_hold(input string nm, input logic [31:0] inst,
                          input int max, output int np);
    np = 0;
    step(inst);
    while (bus.o_pause && np < max) begin
      np++;
      chk({nm, "_stall_we"}, 32'(bus.o_regWe), 32'd0);
      chk({nm, "_stall_dm"}, 32'(bus.o_dMemWe), 32'd0);
      chk({nm, "_stall_br"}, 32'(bus.o_brOP), 32'd0);
      step(inst);
    end
  endtask

  initial begin
    int np;
    tv[0]  = '{32'h2001FFFB, 5'd0,  4'd0, 7'b1000101, 5'd1,  32'hFFFFFFFB, 3'b111};
    tv[1]  = '{32'h34028000, 5'd3,  4'd0, 7'b1000101, 5'd2,  32'h00008000, 3'b111};
    tv[2]  = '{32'h000730C0, 5'd8,  4'd0, 7'b1001000, 5'd6,  32'h00000003, 3'b111};
    tv[3]  = '{32'h0C012345, 5'd0,  4'd8, 7'b1000000, 5'd31, 32'h0,        3'b010};
    tv[4]  = '{32'h04210010, 5'd0,  4'd6, 7'b0000001, 5'd0,  32'h00000010, 3'b001};
    tv[5]  = '{32'h0420FFFF, 5'd0,  4'd5, 7'b0000001, 5'd0,  32'hFFFFFFFF, 3'b001};
    tv[6]  = '{32'h8C040000, 5'd0,  4'd0, 7'b1010101, 5'd4,  32'h00000000, 3'b111};
    tv[7]  = '{32'hA065FFFF, 5'd0,  4'd0, 7'b0100111, 5'd0,  32'hFFFFFFFF, 3'b101};
    tv[8]  = '{32'h3C08FFFF, 5'd11, 4'd0, 7'b1000100, 5'd8,  32'h0000FFFF, 3'b111};
    tv[9]  = '{32'h2829FFFE, 5'd6,  4'd0, 7'b1000101, 5'd9,  32'hFFFFFFFE, 3'b111};
    tv[10] = '{32'h018B5007, 5'd10, 4'd0, 7'b1000001, 5'd10, 32'h0,        3'b110};
    tv[11] = '{32'h03E00008, 5'd0,  4'd9, 7'b0000001, 5'd0,  32'h0,        3'b000};
    tv[12] = '{32'hFC000000, 5'd0,  4'd0, 7'b0000000, 5'd0,  32'h0,        3'b000};
    tv[13] = '{32'h0022182B, 5'd7,  4'd0, 7'b1000001, 5'd3,  32'h0,        3'b110};
    tv[14] = '{32'h08000100, 5'd0,  4'd7, 7'b0000000, 5'd0,  32'h0,        3'b000};
    tv[15] = '{32'h38628001, 5'd4,  4'd0, 7'b1000101, 5'd2,  32'h00008001, 3'b111};
    tv[16] = '{32'hAC220004, 5'd0,  4'd0, 7'b0100101, 5'd0,  32'h00000004, 3'b101};
    tv[17] = '{32'h8043FFFC, 5'd0,  4'd0, 7'b1010111, 5'd3,  32'hFFFFFFFC, 3'b111};
    tv[18] = '{32'h14220008, 5'd0,  4'd2, 7'b0000001, 5'd0,  32'h00000008, 3'b001};
    tv[19] = '{32'h00221827, 5'd5,  4'd0, 7'b1000001, 5'd3,  32'h0,        3'b110};

    bus.i_inst    = NOP;
    bus.i_rd1     = RD1;
    bus.i_rd2     = RD2;
    bus.i_aluOutE = ALUE;
    bus.i_resM    = RESM;
    bus.i_rstW    = RSTW;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.i_inst = 32'h00812822;
    @(negedge clk);
    chk("rst_pause", 32'(bus.o_pause), 32'd0);
    chk("rst_rd1", bus.o_rd1, RD1);
    chk("rst_rd2", bus.o_rd2, RD2);

    for (int i = 0; i < 20; i++) begin
      flush();
      step(tv[i].inst);
      chk($sformatf("v%0d_br", i), 32'(bus.o_brOP), 32'(tv[i].br));
      chk($sformatf("v%0d_we", i), 32'(bus.o_regWe), 32'(tv[i].fl[6]));
      chk($sformatf("v%0d_dm", i), 32'(bus.o_dMemWe), 32'(tv[i].fl[5]));
      chk($sformatf("v%0d_wrd", i), 32'(bus.o_sWRD), 32'(tv[i].fl[4]));
      chk($sformatf("v%0d_sa", i), 32'(bus.o_sA), 32'(tv[i].fl[3]));
      chk($sformatf("v%0d_sb", i), 32'(bus.o_sB), 32'(tv[i].fl[2]));
      chk($sformatf("v%0d_byte", i), 32'(bus.o_sByte), 32'(tv[i].fl[1]));
      chk($sformatf("v%0d_srs", i), 32'(bus.o_srs), 32'(tv[i].fl[0]));
      chk($sformatf("v%0d_tpc", i), 32'(bus.o_targetPC),
          32'(tv[i].inst[25:0]));
      chk($sformatf("v%0d_pause", i), 32'(bus.o_pause), 32'd0);
      chk($sformatf("v%0d_rd1", i), bus.o_rd1, RD1);
      chk($sformatf("v%0d_rd2", i), bus.o_rd2, RD2);
      if (tv[i].m[2])
        chk($sformatf("v%0d_alu", i), 32'(bus.o_aluOP), 32'(tv[i].alu));
      if (tv[i].m[1])
        chk($sformatf("v%0d_wra", i), 32'(bus.o_WRA), 32'(tv[i].wra));
      if (tv[i].m[0])
        chk($sformatf("v%0d_num", i), bus.o_num, tv[i].num);
    end

    // ori $2 then add $3,$2,$2
    flush();
    step(32'h34028000);
    run_hold("eA", 32'h00421820, 6, np);
    chk("eA_npause", 32'(np), FWD ? 32'd0 : 32'd3);
    chk("eA_pause", 32'(bus.o_pause), 32'd0);
    chk("eA_we", 32'(bus.o_regWe), 32'd1);
    chk("eA_rd1", bus.o_rd1, FWD ? ALUE : RD1);
    chk("eA_rd2", bus.o_rd2, FWD ? ALUE : RD2);

    // E has priority over M for the same register
    flush();
    step(32'h2001FFFB);
    step(32'h34018000);
    run_hold("pri", 32'h00211820, 6, np);
    chk("pri_npause", 32'(np), FWD ? 32'd0 : 32'd3);
    chk("pri_rd1", bus.o_rd1, FWD ? ALUE : RD1);

    // addi $1; lw $4; sub $5,$4,$1 (load-use)
    flush();
    step(32'h2001FFFB);
    step(32'h8C040000);
    run_hold("lu", 32'h00812822, 6, np);
    chk("lu_npause", 32'(np), FWD ? 32'd1 : 32'd3);
    chk("lu_pause", 32'(bus.o_pause), 32'd0);
    chk("lu_we", 32'(bus.o_regWe), 32'd1);
    chk("lu_rd1", bus.o_rd1, FWD ? RESM : RD1);
    chk("lu_rd2", bus.o_rd2, FWD ? RSTW : RD2);

    // write to $0 then read $0
    flush();
    step(32'h20000001);
    step(32'h00003820);
    chk("z_pause", 32'(bus.o_pause), 32'd0);
    chk("z_we", 32'(bus.o_regWe), 32'd1);
    chk("z_rd1", bus.o_rd1, RD1);
    chk("z_rd2", bus.o_rd2, RD2);

    // reset while stalled drops the stall next cycle
    flush();
    step(32'h8C040000);
    step(32'h00812822);
    chk("rs_pause_pre", 32'(bus.o_pause), 32'd1);
    chk("rs_we_pre", 32'(bus.o_regWe), 32'd0);
    rst = 1'b1;
    step(32'h00812822);
    chk("rs_pause_post", 32'(bus.o_pause), 32'd0);
    chk("rs_rd1_post", bus.o_rd1, RD1);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
